// File: rtl/idma_ar_burst_gen.sv
// rtl/idma_ar_burst_gen.sv - AXI read-address burst generator with 4KB splitting and outstanding-burst limit
module idma_ar_burst_gen #(
    parameter int AXI_DATA_WID = 256,
    parameter int AXI_ADDR_WID = 32,
    parameter int AXI_LENW     = 4,
    parameter int AXI_IDW      = 4,
    parameter int AR_ID        = 0,
    parameter int OSTD_W       = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [OSTD_W-1:0]       cfg_outstd,
    input  logic                    cfg_cross4k_en,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [AXI_ADDR_WID-1:0] req_addr,
    input  logic [31:0]             req_num,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [AXI_IDW-1:0]      arid,
    output logic [AXI_ADDR_WID-1:0] araddr,
    output logic [AXI_LENW-1:0]     arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    input  logic                    rvalid,
    input  logic                    rready,
    input  logic                    rlast,
    output logic                    busy,
    output logic                    done,
    output logic [OSTD_W-1:0]       ostd_cnt
);

    localparam int          BSZ_LOG   = $clog2(AXI_DATA_WID / 8);
    localparam logic [31:0] MAX_BEATS = 32'd1 << AXI_LENW;
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << BSZ_LOG) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       cur_addr;
    logic [31:0]       remaining;
    logic [31:0]       cur_len;
    logic [31:0]       burst_len;
    logic [31:0]       beats_to_4k;
    logic [12:0]       bytes_to_4k;
    logic [OSTD_W-1:0] eff_limit;
    logic [OSTD_W-1:0] ostd_nxt;
    logic              ar_hs;
    logic              last_hs;
    logic              r_dec;
    logic              can_issue;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign arsize    = 3'(BSZ_LOG);
    assign arburst   = 2'b01;
    assign arid      = AXI_IDW'(AR_ID);

    assign ar_hs     = arvalid & arready;
    // cur_len holds the length of the burst on the bus, so this is the final burst
    assign last_hs   = ar_hs && (remaining == cur_len);
    assign eff_limit = (cfg_outstd == '0) ? OSTD_W'(1) : cfg_outstd;
    assign can_issue = (state == S_IDLE) ? 1'b0 :
                       ((state == S_ISSUE) && !arvalid && (remaining != 32'd0) && (ostd_cnt < eff_limit));

    // Next burst length: remaining beats clipped to max burst and, optionally, to the 4KB page end
    always_comb begin
        bytes_to_4k = 13'h1000 - {1'b0, cur_addr[11:0]};
        beats_to_4k = 32'(bytes_to_4k >> BSZ_LOG);
        burst_len   = remaining;
        if (burst_len > MAX_BEATS) begin
            burst_len = MAX_BEATS;
        end
        if (!cfg_cross4k_en && (burst_len > beats_to_4k)) begin
            burst_len = beats_to_4k;
        end
    end

    // Outstanding count: an rlast with nothing outstanding is stray and dropped
    always_comb begin
        r_dec    = rvalid && rready && rlast && (ostd_cnt != '0);
        ostd_nxt = ostd_cnt;
        if (ar_hs && !r_dec) begin
            ostd_nxt = ostd_cnt + OSTD_W'(1);
        end else if (!ar_hs && r_dec) begin
            ostd_nxt = ostd_cnt - OSTD_W'(1);
        end
    end

    // Command sequencing: IDLE -> ISSUE -> DRAIN -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid && (req_num != 32'd0)) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_hs) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ostd_nxt == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latch, AR channel registers, outstanding counter and done pulse
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cur_addr  <= 32'd0;
            remaining <= 32'd0;
            cur_len   <= 32'd0;
            arvalid   <= 1'b0;
            araddr    <= '0;
            arlen     <= '0;
            ostd_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            ostd_cnt <= ostd_nxt;
            done     <= ((state == S_IDLE) && req_valid && (req_num == 32'd0)) ||
                        ((state == S_DRAIN) && (state_nxt == S_IDLE));
            if ((state == S_IDLE) && req_valid) begin
                cur_addr  <= 32'(req_addr) & ADDR_MASK;
                remaining <= req_num;
            end
            if (can_issue) begin
                arvalid <= 1'b1;
                araddr  <= cur_addr[AXI_ADDR_WID-1:0];
                arlen   <= AXI_LENW'(burst_len - 32'd1);
                cur_len <= burst_len;
            end else if (ar_hs) begin
                arvalid   <= 1'b0;
                cur_addr  <= cur_addr + (cur_len << BSZ_LOG);
                remaining <= remaining - cur_len;
            end
        end
    end

endmodule

// File: doc/idma_ar_burst_gen.md
IDMA_AR_BURST_GEN -- requirements
Module: idma_ar_burst_gen

Interface
REQ-001 Parameter AXI_DATA_WID, default 256: AXI data width in bits; legal values are 64, 128, 256 and 512.
REQ-002 Parameter AXI_ADDR_WID, default 32: address width.
REQ-003 Parameter AXI_LENW, default 4: arlen width; maximum burst is 2^AXI_LENW beats.
REQ-004 Parameter AXI_IDW, default 4: arid width.
REQ-005 Parameter AR_ID, default 0: constant arid value.
REQ-006 Parameter OSTD_W, default 4: outstanding counter width.
REQ-007 aclk  in  1  sole clock; all logic is on the rising edge.
REQ-008 aresetn  in  1  reset, asynchronous and active-low.
REQ-009 cfg_outstd  in  OSTD_W  outstanding-burst limit; a value of 0 is treated as 1.
REQ-010 cfg_cross4k_en  in  1  1 = bursts may cross a 4KB boundary; 0 = bursts are split at 4KB.
REQ-011 req_valid / req_ready  in / out  1  command handshake.
REQ-012 req_addr  in  AXI_ADDR_WID  start byte address.
REQ-013 req_num  in  32  length in beats.
REQ-014 arvalid / arready  out / in  1  AXI AR handshake.
REQ-015 arid  out  AXI_IDW; araddr  out  AXI_ADDR_WID; arlen  out  AXI_LENW.
REQ-016 arsize  out  3; arburst  out  2.
REQ-017 rvalid, rready, rlast  in  1 each  R-channel monitor inputs; this block does not drive rready.
REQ-018 busy  out  1  high while a command is in progress.
REQ-019 done  out  1  single-cycle completion pulse.
REQ-020 ostd_cnt  out  OSTD_W  number of issued bursts still awaiting rlast.

Function
REQ-021 The block SHALL implement three states:
- IDLE: req_ready=1.
- ISSUE: generates AR bursts.
- DRAIN: waits for ostd_cnt to reach 0.
REQ-022 On a req_valid&req_ready handshake, the block SHALL latch the command, force the address low log2(AXI_DATA_WID/8) bits to 0, and enter ISSUE.
- If req_num==0, it SHALL instead pulse done on the next cycle and stay in IDLE, issuing no AR.
REQ-023 Burst length (beats) SHALL be the minimum of:
- remaining beats;
- 2^AXI_LENW;
- beats to the next 4KB boundary, only when cfg_cross4k_en=0.
arlen SHALL equal length-1.
REQ-024 After each AR handshake, the block SHALL advance the next address by length*(AXI_DATA_WID/8) and reduce remaining beats by length.
- Internal arithmetic is 32-bit unsigned.
- Address wrap at 2^AXI_ADDR_WID is permitted.
REQ-025 arsize SHALL be the constant log2(AXI_DATA_WID/8).
REQ-026 arburst SHALL be the constant 2'b01 (INCR); arid SHALL be the constant AR_ID.
REQ-027 All AR outputs SHALL be registered.
REQ-028 Once arvalid is asserted, arvalid, araddr and arlen SHALL stay stable until arready.
REQ-029 arvalid SHALL rise only when ostd_cnt is below the effective limit and remaining beats > 0.
- There is at most one cycle bubble between back-to-back bursts.
- Back-to-back issue with arready held high SHALL be supported.
REQ-030 ostd_cnt update rules:
- +1 on an AR handshake.
- -1 on rvalid&rready&rlast.
- Unchanged when both occur in the same cycle.
- No decrement at 0; an rlast arriving at 0 is ignored.
REQ-031 When the last burst handshakes, the block SHALL go ISSUE -> DRAIN, and then go DRAIN -> IDLE in the cycle ostd_cnt becomes 0.
REQ-032 done SHALL be high for exactly one cycle, the first IDLE cycle after DRAIN.
REQ-033 busy SHALL be 1 in ISSUE and DRAIN.
REQ-034 req_valid SHALL be ignored while not in IDLE.
REQ-035 cfg_* inputs SHALL be sampled continuously; changes mid-command take effect for the next burst issued.

Reset
REQ-036 While aresetn=0, the block SHALL force:
- state to IDLE;
- arvalid, done, busy, ostd_cnt, araddr and arlen to 0;
- req_ready to 1.
REQ-037 Reset asserted mid-command SHALL abandon the command and all outstanding bursts immediately; no done pulse is produced.

Verification (AXI_DATA_WID=256: 32B/beat, 128 beats per 4KB)
REQ-038 addr 0x1000, num 16, arready=1 -> one AR: araddr 0x1000, arlen 15, arsize 5, arburst 1. After rlast, done pulses once and ostd_cnt=0.
REQ-039 addr 0x0, num 40, cfg_outstd=4 -> three ARs: (0x000, arlen 15), (0x200, 15), (0x400, 7). done follows the third rlast.
REQ-040 addr 0x0FC0, num 4:
- cfg_cross4k_en=0 -> (0x0FC0, arlen 1) then (0x1000, arlen 1).
- cfg_cross4k_en=1 -> single (0x0FC0, arlen 3).
REQ-041 cfg_outstd=2, num 64, arready=1, no rlast -> exactly 2 ARs, then arvalid=0 and ostd_cnt=2. One rlast -> third AR issues; ostd_cnt stays 2 because the increment and decrement coincide, or passes through 1 otherwise.
REQ-042 req_num=0 -> done pulses one cycle after the handshake; arvalid never rises; busy stays 0.
REQ-043 aresetn low during the second burst of a 40-beat command -> all outputs return to reset values asynchronously; after release, a new 16-beat command completes normally.
